// File: rtl/cnt_job_sched.sv
// Round-robin scheduler that hands one shared countdown counter to NREQ requesters in turn.
// Define CNT_JOB_SCHED_FIXED_PRIO_EN to switch arbitration to fixed lowest-index priority.
module cnt_job_sched #(
    parameter int BITS = 4,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic                 cnt_load,
    output logic                 cnt_on,
    output logic                 cnt_up,
    output logic [BITS-1:0]      cnt_data,
    input  logic [BITS-1:0]      cnt_value
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   winner;
    logic            found;
    logic [BITS-1:0] len_arr [NREQ];
`ifndef CNT_JOB_SCHED_FIXED_PRIO_EN
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cand;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            len_arr[i] = len[i*BITS +: BITS];
        end
    end

    // Winner search: first requesting bit after the last grant, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
`ifdef CNT_JOB_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[IW'(k)]) begin
                winner = IW'(k);
                found  = 1'b1;
            end
        end
`else
        cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counter control decodes straight from state so the counter reacts in the same cycle.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_on     = 1'b0;
        cnt_up     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (found) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                cnt_load   = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                cnt_on = (cnt_value != '0);
                if (cnt_value == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // done is registered on the RUN->DONE edge so it lines up with the DONE state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt      <= '0;
            done     <= '0;
            cnt_data <= '0;
            owner    <= '0;
`ifndef CNT_JOB_SCHED_FIXED_PRIO_EN
            ptr      <= IW'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= onehot(winner);
                        owner    <= winner;
                        cnt_data <= len_arr[winner];
`ifndef CNT_JOB_SCHED_FIXED_PRIO_EN
                        ptr      <= winner;
`endif
                    end
                end
                RUN: begin
                    if (cnt_value == '0) begin
                        done <= onehot(owner);
                    end
                end
                DONE: begin
                    gnt  <= '0;
                    done <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_job_sched.sv
// Self-checking bench for cnt_job_sched with a behavioural shared counter and a job-level timeline model.
// Honours CNT_JOB_SCHED_FIXED_PRIO_EN for the expected arbitration order.
module tb_cnt_job_sched;

    localparam int BITS = 4;
    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] len;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 busy;
    logic                 cnt_load;
    logic                 cnt_on;
    logic                 cnt_up;
    logic [BITS-1:0]      cnt_data;
    logic [BITS-1:0]      cnt_value;

    int errors = 0;
    int checks = 0;
    int m_ptr  = NREQ - 1;

    always #5 clk = ~clk;

    cnt_job_sched #(.BITS(BITS), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .len       (len),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cnt_load  (cnt_load),
        .cnt_on    (cnt_on),
        .cnt_up    (cnt_up),
        .cnt_data  (cnt_data),
        .cnt_value (cnt_value)
    );

    // Shared loadable up/down counter, reset by the same net as the scheduler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         cnt_value <= '0;
        else if (cnt_load) cnt_value <= cnt_data;
        else if (cnt_on)   cnt_value <= cnt_up ? cnt_value + 1'b1 : cnt_value - 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        onehot = NREQ'(1) << i;
    endfunction

    // Expected winner from the arbitration rule, independent of any RTL encoding.
    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        pick = -1;
`ifdef CNT_JOB_SCHED_FIXED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) if (r[k]) pick = k;
`else
        for (int k = NREQ; k >= 1; k--) if (r[(last + k) % NREQ]) pick = (last + k) % NREQ;
`endif
    endfunction

    task automatic model_grant(input int w);
`ifndef CNT_JOB_SCHED_FIXED_PRIO_EN
        m_ptr = w;
`endif
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (gnt == '0 && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (gnt == '0) begin
            errors++;
            $display("[TB] FAIL grant_timeout: got gnt=%b after %0d cycles, required a grant", gnt, cyc);
        end
    endtask

    // Called right after the grant edge; walks the job timeline and ends in the following IDLE cycle.
    task automatic check_job(input int w, input int l, input int mode);
        logic [NREQ-1:0] e_gnt, e_done;
        logic            e_busy, e_load, e_on;
        int              rem;
        for (int c = 0; c <= l + 3; c++) begin
            rem    = l - (c - 1);
            if (rem < 0) rem = 0;
            e_gnt  = (c <= l + 2) ? onehot(w) : '0;
            e_done = (c == l + 2) ? onehot(w) : '0;
            e_busy = (c <= l + 2);
            e_load = (c == 0);
            e_on   = (c >= 1) && (c <= l + 1) && (rem != 0);
            checks++;
            if (gnt !== e_gnt) begin
                errors++;
                $display("[TB] FAIL gnt c=%0d: got %b required %b", c, gnt, e_gnt);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("[TB] FAIL done c=%0d: got %b required %b", c, done, e_done);
            end
            checks++;
            if (busy !== e_busy || cnt_load !== e_load || cnt_on !== e_on || cnt_up !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ctrl c=%0d: got busy/load/on/up=%b%b%b%b required %b%b%b0",
                         c, busy, cnt_load, cnt_on, cnt_up, e_busy, e_load, e_on);
            end
            if (c >= 1) begin
                checks++;
                if (cnt_value !== BITS'(rem)) begin
                    errors++;
                    $display("[TB] FAIL count c=%0d: got %0d required %0d", c, cnt_value, rem);
                end
            end else begin
                checks++;
                if (cnt_data !== BITS'(l)) begin
                    errors++;
                    $display("[TB] FAIL cnt_data: got %0d required %0d", cnt_data, l);
                end
            end
            if (mode == 1 && c == 1) begin
                req = NREQ'($urandom);
                len = (NREQ*BITS)'($urandom);
            end
            if (mode == 2 && c == 2) begin
                req[w]              = 1'b0;
                len[w*BITS +: BITS] = BITS'(15);
            end
            if (c < l + 3) step();
        end
    endtask

    task automatic do_reset();
        req   = '0;
        len   = '0;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        m_ptr = NREQ - 1;
    endtask

    task automatic test_reset();
        req   = '0;
        len   = '0;
        reset = 1'b1;
        #3;
        checks++;
        if (gnt !== '0 || done !== '0 || busy !== 1'b0 || cnt_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got gnt=%b done=%b busy=%b data=%0d required all zero",
                     gnt, done, busy, cnt_data);
        end
        repeat (2) step();
        reset = 1'b0;
        m_ptr = NREQ - 1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (gnt !== '0 || done !== '0 || busy !== 1'b0 || cnt_load !== 1'b0 ||
                cnt_on !== 1'b0 || cnt_up !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_%0d: got gnt=%b done=%b busy=%b load=%b on=%b up=%b required all zero",
                         i, gnt, done, busy, cnt_load, cnt_on, cnt_up);
            end
        end
    endtask

    task automatic run_one(input logic [NREQ-1:0] r, input int mode, input int exp_cyc);
        logic [BITS-1:0] lens [NREQ];
        int              w, cyc;
        req = r;
        for (int i = 0; i < NREQ; i++) lens[i] = len[i*BITS +: BITS];
        w = pick(r, m_ptr);
        wait_grant(cyc);
        checks++;
        if (cyc != exp_cyc) begin
            errors++;
            $display("[TB] FAIL grant_latency: got %0d cycles required %0d", cyc, exp_cyc);
        end
        model_grant(w);
        check_job(w, int'(lens[w]), mode);
    endtask

    task automatic test_single();
        len = '0;
        len[1*BITS +: BITS] = BITS'(3);
        run_one(4'b0010, 0, 1);
        req = '0;
    endtask

    task automatic test_len_zero();
        len = '0;
        run_one(4'b0001, 0, 1);
        req = '0;
    endtask

    task automatic test_round_robin();
        int exp_order [5];
`ifdef CNT_JOB_SCHED_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        len = 16'h1111;
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (pick(4'b1111, m_ptr) != exp_order[j]) begin
                errors++;
                $display("[TB] FAIL rr_order_%0d: model winner %0d required %0d", j, pick(4'b1111, m_ptr), exp_order[j]);
            end
            run_one(4'b1111, 0, 1);
        end
        req = '0;
    endtask

    task automatic test_stability();
        len = '0;
        len[2*BITS +: BITS] = BITS'(5);
        run_one(4'b0100, 2, 1);
        req = '0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] r;
        for (int j = 0; j < 25; j++) begin
            do r = NREQ'($urandom); while (r == '0);
            len = (NREQ*BITS)'($urandom);
            run_one(r, 1, 1);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        len = '0;
        len[3*BITS +: BITS] = BITS'(5);
        req = 4'b1000;
        wait_grant(cyc);
        repeat (4) step();
        checks++;
        if (cnt_value !== BITS'(2) || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_run_count: got %0d busy=%b required 2 busy=1", cnt_value, busy);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (gnt !== '0 || done !== '0 || busy !== 1'b0 || cnt_load !== 1'b0 || cnt_on !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_abort: got gnt=%b done=%b busy=%b load=%b on=%b required all zero",
                     gnt, done, busy, cnt_load, cnt_on);
        end
        req = 4'b1111;
        len = 16'h2222;
        repeat (2) step();
        checks++;
        if (done !== '0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %b required 0000", done);
        end
        reset = 1'b0;
        m_ptr = NREQ - 1;
        wait_grant(cyc);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL post_reset_grant: got %b required 0001", gnt);
        end
        model_grant(0);
        check_job(0, 2, 0);
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_len_zero();
        test_round_robin();
        test_stability();
        test_random();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnt_job_sched.md
Name: cnt_job_sched

Overview:
- Round-robin scheduler that shares one loadable up/down counter (ports: load, counter_on, count_up, data_in, count) among NREQ requesters.
- Each requester asks for a countdown job of a programmable length.
- The scheduler grants one requester at a time, loads the counter, runs it down to zero and pulses a per-requester done.
- It drives the counter's control inputs directly and observes the counter's count output.

Parameters:
- BITS, 4, counter width; also the width of each job length.
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; same net also resets the shared counter
- req  in  NREQ  per-requester job request, level
- len  in  NREQ*BITS  packed job lengths; requester i uses bits [i*BITS +: BITS]
- gnt  out  NREQ  one-hot grant, held for the whole job
- done  out  NREQ  one-cycle completion pulse to the owner
- busy  out  1  high whenever state is not IDLE
- cnt_load  out  1  to counter load
- cnt_on  out  1  to counter counter_on
- cnt_up  out  1  to counter count_up; constant 0 (countdown only)
- cnt_data  out  BITS  to counter data_in
- cnt_value  in  BITS  from counter count

Behaviour:
- Reset, asynchronous and immediate:
  - state = IDLE; gnt = 0; done = 0; busy = 0.
  - cnt_load = 0; cnt_on = 0; cnt_up = 0; cnt_data = 0.
  - owner = 0; last-grant pointer = NREQ-1, so req[0] has first priority.
- Reset mid-job aborts the job. No done is issued.
- States: IDLE, LOAD, RUN, DONE. gnt, done and cnt_data are registered. cnt_load, cnt_on and busy decode from state (and cnt_value).
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from pointer+1, wrapping modulo NREQ.
  - On that edge: gnt <= onehot(winner), owner <= winner, pointer <= winner, cnt_data <= len[winner], state <= LOAD.
  - No req means stay in IDLE with all outputs low.
- LOAD (1 cycle): cnt_load = 1, cnt_on = 0. The counter takes cnt_data at the edge. Next state RUN.
- RUN:
  - cnt_load = 0; cnt_on = (cnt_value != 0); cnt_up = 0.
  - If cnt_value == 0, next state is DONE. Otherwise stay in RUN; the counter decrements each cycle.
- DONE (1 cycle): done[owner] = 1, gnt still asserted. At the edge: gnt <= 0, done <= 0, state <= IDLE.
- Timing: with gnt rising at edge t, there is LOAD at t, RUN for len+1 cycles, and DONE at cycle t+len+2. gnt is high for len+3 cycles.
- len = 0: a single RUN cycle observes 0, and done follows 2 cycles after LOAD.
- Minimum gap between jobs: one IDLE cycle, since arbitration happens only in IDLE.
- Inputs during a job:
  - req changes during a job are ignored; the job always completes.
  - len is captured only at grant, so later len changes have no effect.
  - A requester may hold req high continuously and will be re-granted according to the rotation.
- Counter underflow never occurs, because cnt_on is gated by cnt_value != 0.
- gnt and done are never multi-hot.

Optional Feature:
- Macro: CNT_JOB_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index requesting bit always wins and the pointer is unused (held at reset value).
- Undefined (default): round-robin as described above.
- All timing is identical in both modes.

Test Plan:
- Reset, then idle: no req for 5 cycles -> gnt = 0, done = 0, busy = 0, cnt_load = 0, cnt_on = 0, cnt_up = 0.
- Single job: req[1] = 1, len[1] = 3 at cycle 0 -> gnt = 0010 from cycle 1 to 6, cnt_load = 1 at cycle 1, counter 3,2,1,0 over cycles 2-5, done = 0010 at cycle 6 only, gnt = 0 at cycle 7.
- len = 0: req[0] with len 0 -> LOAD, one RUN cycle, then done[0] 3 cycles after grant; cnt_on never asserted; counter stays 0.
- Round-robin: req = 1111 held high, all len = 1 -> grant order 0,1,2,3,0; each gnt lasts 4 cycles, separated by 1 IDLE cycle. With CNT_JOB_SCHED_FIXED_PRIO_EN defined -> order 0,0,0,...
- Stability: drop req[2] and change len[2] to 15 in the middle of a 5-cycle job -> the job still completes on the original length with done[2] pulsed.
- Reset mid-RUN: assert reset with cnt_value = 2 -> gnt, done and busy go to 0 immediately, no done pulse, next grant goes to req[0] first.
